// File: rtl/multiplicador_pkg.sv
// Shared constants for the shift-add multiplier family: default widths and the
// state encoding used by the sequencer, control unit and datapath.
package multiplicador_pkg;

    localparam int unsigned N_DEFAULT       = 4;
    localparam int unsigned TIMEOUT_DEFAULT = 64;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] START   = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;
    localparam logic [1:0] OUT     = 2'd3;

    typedef enum logic [1:0] {
        StIdle    = IDLE,
        StStart   = START,
        StRelease = RELEASE,
        StOut     = OUT
    } state_t;

endpackage

// File: rtl/multiplicador_seq_if.sv
// Operand/result channels and multiplier handshake seen by the sequencer.
// master: the sequencer. slave: producer, multiplier and consumer side.
interface multiplicador_seq_if import multiplicador_pkg::*; #(
    parameter int unsigned N = N_DEFAULT
) ();

    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   in_a;
    logic [N-1:0]   in_b;
    logic           mul_start;
    logic [N-1:0]   mul_a;
    logic [N-1:0]   mul_b;
    logic           mul_done;
    logic [2*N-1:0] mul_prod;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] out_prod;
    logic           out_err;

    modport master (
        input  in_valid, in_a, in_b, mul_done, mul_prod, out_ready,
        output in_ready, mul_start, mul_a, mul_b, out_valid, out_prod, out_err
    );

    modport slave (
        output in_valid, in_a, in_b, mul_done, mul_prod, out_ready,
        input  in_ready, mul_start, mul_a, mul_b, out_valid, out_prod, out_err
    );

endinterface

// File: rtl/multiplicador_timer.sv
// Watchdog counter: counts enabled cycles from a clear, saturating at
// TIMEOUT-1 where the terminal-count flag is raised.
module multiplicador_timer #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int unsigned W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] cnt_q;

    // Clear wins over enable; hold at the terminal count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && !tc) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    // Flag decoded from the count register only
    always_comb begin
        tc = (cnt_q == LAST);
    end

endmodule

// File: rtl/multiplicador_seq.sv
// Operand sequencer in front of the shift-add multiplier. Holds operands,
// runs the four-phase start/done handshake, captures the product and offers
// it downstream. A watchdog turns a silent or stuck multiplier into an error.
module multiplicador_seq import multiplicador_pkg::*; #(
    parameter int unsigned N       = N_DEFAULT,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    multiplicador_seq_if.master bus,
    output logic                busy,
    output logic [7:0]          ops_cnt
);

    state_t         state_q;
    logic [N-1:0]   a_q;
    logic [N-1:0]   b_q;
    logic [2*N-1:0] prod_q;
    logic           err_q;
    logic [7:0]     ops_q;

    logic wd_clr;
    logic wd_en;
    logic wd_tc;

    // Watchdog runs in START and RELEASE, restarting on every phase entry
    always_comb begin
        wd_en  = (state_q == StStart) || (state_q == StRelease);
        wd_clr = (state_q == StIdle) ||
                 ((state_q == StStart) && (bus.mul_done || wd_tc));
    end

    multiplicador_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .clr (wd_clr),
        .en  (wd_en),
        .tc  (wd_tc)
    );

    // Sequencer FSM with its registered operand/result state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
            err_q   <= 1'b0;
            ops_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.in_a;
                        b_q     <= bus.in_b;
                        err_q   <= 1'b0;
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    if (bus.mul_done) begin
                        prod_q  <= bus.mul_prod;
                        state_q <= StRelease;
                    end else if (wd_tc) begin
                        err_q   <= 1'b1;
                        prod_q  <= '0;
                        state_q <= StRelease;
                    end
                end
                StRelease: begin
                    if (!bus.mul_done) begin
                        state_q <= StOut;
                    end else if (wd_tc) begin
                        // Product already captured; keep it, flag the stuck done
                        err_q   <= 1'b1;
                        state_q <= StOut;
                    end
                end
                StOut: begin
                    if (bus.out_ready) begin
                        if (!err_q) begin
                            ops_q <= ops_q + 8'd1;
                        end
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Outputs come from registers or state decode only
    always_comb begin
        bus.in_ready  = (state_q == StIdle);
        bus.mul_start = (state_q == StStart);
        bus.out_valid = (state_q == StOut);
        bus.mul_a     = a_q;
        bus.mul_b     = b_q;
        bus.out_prod  = prod_q;
        bus.out_err   = err_q;
        busy          = (state_q != StIdle);
        ops_cnt       = ops_q;
    end

endmodule

// File: tb/tb_multiplicador_seq.sv
// Directed bench for multiplicador_seq with a behavioural multiplier that can
// answer normally, never answer, or hold done high forever.
module tb_multiplicador_seq;

    localparam int LAT = 2;

    logic       clk;
    logic       rst;
    logic [7:0] ops_cnt;
    logic       busy;

    multiplicador_seq_if #(.N(4)) bus ();

    multiplicador_seq #(
        .N       (4),
        .TIMEOUT (64)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .busy    (busy),
        .ops_cnt (ops_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier model: 0 = normal, 1 = never answers, 2 = done stuck high
    int         mode;
    int         mcnt;
    logic       mdone;
    logic [7:0] mprod;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mdone <= 1'b0;
            mcnt  <= 0;
            mprod <= 8'h00;
        end else if (mode == 1) begin
            mdone <= 1'b0;
        end else if (bus.mul_start) begin
            if (!mdone) begin
                if (mcnt == LAT - 1) begin
                    mdone <= 1'b1;
                    mprod <= {4'b0, bus.mul_a} * {4'b0, bus.mul_b};
                    mcnt  <= 0;
                end else begin
                    mcnt <= mcnt + 1;
                end
            end
        end else if (mode == 0) begin
            mdone <= 1'b0;
            mcnt  <= 0;
        end
    end

    assign bus.mul_done = mdone;
    assign bus.mul_prod = mprod;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_ops = 8'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " in_ready"}, 32'(bus.in_ready), 1);
        chk({tag, " mul_start"}, 32'(bus.mul_start), 0);
        chk({tag, " mul_ab"}, 32'({bus.mul_a, bus.mul_b}), 0);
        chk({tag, " out_valid"}, 32'(bus.out_valid), 0);
        chk({tag, " out_prod"}, 32'(bus.out_prod), 0);
        chk({tag, " out_err"}, 32'(bus.out_err), 0);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " ops_cnt"}, 32'(ops_cnt), 0);
    endtask

    // One operation with out_ready already high; exp_cyc counts from the cycle
    // after the accepting edge (1) to the first out_valid cycle.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                          input logic [7:0] exp_prod, input logic exp_err,
                          input int exp_cyc, input string tag);
        int cyc;
        bit got;
        bit seen_start;
        @(negedge clk);
        chk({tag, " idle ready"}, 32'(bus.in_ready), 1);
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        cyc        = 0;
        got        = 1'b0;
        seen_start = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            cyc++;
            if (bus.mul_start) seen_start = 1'b1;
            if (bus.out_valid) got = 1'b1;
        end
        chk({tag, " out_valid seen"}, 32'(got), 1);
        chk({tag, " latency"}, 32'(cyc), 32'(exp_cyc));
        chk({tag, " start pulsed and low"}, 32'({seen_start, bus.mul_start}), 32'h2);
        chk({tag, " out_prod"}, 32'(bus.out_prod), 32'(exp_prod));
        chk({tag, " out_err"}, 32'(bus.out_err), 32'(exp_err));
        if (!exp_err) exp_ops = exp_ops + 8'd1;
        @(negedge clk);
        chk({tag, " valid dropped"}, 32'({bus.out_valid, bus.in_ready}), 32'h1);
        chk({tag, " ops_cnt"}, 32'(ops_cnt), 32'(exp_ops));
    endtask

    initial begin
        int  cyc;
        bit  got;
        logic [3:0] la;
        logic [3:0] lb;
        logic [7:0] lp;

        mode          = 0;
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;

        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals("post reset idle");

        // Basic products, including the full-width corner and a zero operand
        run_op(4'd13, 4'd11, 8'h8F, 1'b0, LAT + 4, "13x11");
        run_op(4'd15, 4'd15, 8'hE1, 1'b0, LAT + 4, "15x15");
        run_op(4'd0,  4'd9,  8'h00, 1'b0, LAT + 4, "0x9");

        // Consumer stall with a competing offer that must not be sampled
        @(negedge clk);
        bus.in_a      = 4'd5;
        bus.in_b      = 4'd3;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            if (bus.out_valid) got = 1'b1;
        end
        chk("stall out_valid seen", 32'(got), 1);
        for (int j = 0; j < 10; j++) begin
            if (j == 2) begin
                bus.in_a     = 4'd9;
                bus.in_b     = 4'd9;
                bus.in_valid = 1'b1;
            end
            @(negedge clk);
            chk("stall valid/ready", 32'({bus.out_valid, bus.in_ready}), 32'h2);
            chk("stall out_prod", 32'(bus.out_prod), 32'd15);
            chk("stall out_err", 32'(bus.out_err), 0);
            chk("stall mul_ab", 32'({bus.mul_a, bus.mul_b}), 32'h53);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        exp_ops = exp_ops + 8'd1;
        @(negedge clk);
        chk("stall release", 32'({bus.out_valid, bus.in_ready}), 32'h1);
        chk("stall ops_cnt", 32'(ops_cnt), 32'(exp_ops));

        // Multiplier never answers: 64 START cycles, one RELEASE, then OUT
        mode = 1;
        run_op(4'd6, 4'd7, 8'h00, 1'b1, 66, "dead mul");
        mode = 0;

        // Done stuck high: product captured, RELEASE times out after 64 cycles
        mode = 2;
        run_op(4'd3, 4'd4, 8'd12, 1'b1, LAT + 66, "stuck done");
        mode = 0;
        @(negedge clk);
        chk("stuck done cleared", 32'(bus.mul_done), 0);

        // Reset in the middle of START
        @(negedge clk);
        bus.in_a     = 4'd2;
        bus.in_b     = 4'd2;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("pre-reset mul_start", 32'(bus.mul_start), 1);
        rst = 1'b0;
        #1;
        chk_reset_vals("mid-op reset");
        @(negedge clk);
        chk("held reset mul_start", 32'(bus.mul_start), 0);
        rst = 1'b1;
        exp_ops = 8'd0;
        run_op(4'd7, 4'd6, 8'd42, 1'b0, LAT + 4, "7x6 after reset");

        // Counter wrap: 255 more error-free operations bring ops_cnt to 0
        for (int i = 0; i < 255; i++) begin
            la = 4'(i);
            lb = 4'(i * 7 + 3);
            lp = {4'b0, la} * {4'b0, lb};
            @(negedge clk);
            bus.in_a     = la;
            bus.in_b     = lb;
            bus.in_valid = 1'b1;
            got = 1'b0;
            cyc = 0;
            for (int k = 0; k < 200 && !got; k++) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
                cyc++;
                if (bus.out_valid) got = 1'b1;
            end
            chk("wrap op done", 32'({got, bus.out_err}), 32'h2);
            chk("wrap op prod", 32'(bus.out_prod), 32'(lp));
            @(negedge clk);
            if (i == 253) chk("ops_cnt at 255", 32'(ops_cnt), 32'd255);
        end
        chk("ops_cnt wrapped", 32'(ops_cnt), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
